// File: rtl/pwl_tanh_arbiter.sv
// ---------------------------------------------------------------------------
// pwl_tanh_arbiter
//
// Shares one fixed-latency tanh unit among NUM_REQ requesters. Requests are
// granted round-robin, every in-flight sample carries its owner index through
// a TANH_LAT-deep tag pipeline, and each result lands in a 1-deep response
// slot owned by the requester that issued it.
//
// A requester is only granted when its slot is empty and it has nothing in
// flight. A result therefore always finds its slot empty, so no overwrite or
// drop logic is needed.
//
// Optional build macro: PWL_TANH_ARB_STATS_EN adds saturating grant/stall
// counters with a synchronous clear.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   req_valid/ready     per-requester request handshake (ready is one-hot or 0)
//   req_data            packed Q8.8 inputs, requester i at [i*DATA_W +: DATA_W]
//   resp_valid/ready    per-requester response handshake
//   resp_data           packed results, same packing as req_data
//   tanh_valid_in/x_in  issue side of the shared tanh unit
//   tanh_valid_out/y_out result side of the shared tanh unit
//   stat_clr            (macro only) synchronous clear of both counters
//   stat_grants         (macro only) saturating count of issued samples
//   stat_stall          (macro only) saturating count of stalled cycles
// ---------------------------------------------------------------------------
module pwl_tanh_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int DATA_W   = 16,
    parameter int TANH_LAT = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        resp_valid,
    input  logic [NUM_REQ-1:0]        resp_ready,
    output logic [NUM_REQ*DATA_W-1:0] resp_data,
    output logic                      tanh_valid_in,
    output logic [DATA_W-1:0]         tanh_x_in,
    input  logic                      tanh_valid_out,
    input  logic [DATA_W-1:0]         tanh_y_out
`ifdef PWL_TANH_ARB_STATS_EN
    ,
    input  logic                      stat_clr,
    output logic [31:0]               stat_grants,
    output logic [31:0]               stat_stall
`endif
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [IDX_W-1:0]          ptr_q, ptr_d;
    logic [NUM_REQ-1:0]        slot_v_q, slot_v_d;
    logic [NUM_REQ*DATA_W-1:0] slot_data_q, slot_data_d;
    logic                      tag_v_q   [TANH_LAT];
    logic [IDX_W-1:0]          tag_idx_q [TANH_LAT];

    logic [NUM_REQ-1:0]        in_flight;
    logic [NUM_REQ-1:0]        eligible;
    logic [NUM_REQ-1:0]        grant;
    logic                      gnt_any;
    logic [IDX_W-1:0]          gnt_idx;
    logic                      exit_v;
    logic [IDX_W-1:0]          exit_idx;
    logic                      capture;
    int                        rr_j;

    assign exit_v   = tag_v_q[TANH_LAT-1];
    assign exit_idx = tag_idx_q[TANH_LAT-1];
    assign capture  = exit_v & tanh_valid_out;

    always_comb begin
        in_flight = '0;
        for (int s = 0; s < TANH_LAT; s++) begin
            if (tag_v_q[s]) begin
                in_flight[tag_idx_q[s]] = 1'b1;
            end
        end
    end

    assign eligible = req_valid & ~slot_v_q & ~in_flight;

    // Round-robin search starting at the pointer. Gating with rst_n keeps
    // req_ready and tanh_valid_in low while reset is held, since the
    // cleared state would otherwise make every valid requester eligible.
    always_comb begin
        grant   = '0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        rr_j    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            rr_j = int'(ptr_q) + k;
            if (rr_j >= NUM_REQ) begin
                rr_j = rr_j - NUM_REQ;
            end
            if (!gnt_any && eligible[rr_j] && rst_n) begin
                gnt_any     = 1'b1;
                gnt_idx     = IDX_W'(rr_j);
                grant[rr_j] = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (gnt_any) begin
            ptr_d = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    assign req_ready     = grant;
    assign tanh_valid_in = gnt_any;
    assign tanh_x_in     = gnt_any ? req_data[gnt_idx*DATA_W +: DATA_W] : '0;

    // Handshake clears the slot; a capture fills it. Both never hit the same
    // slot in one cycle because a full slot blocks its owner from issuing.
    always_comb begin
        slot_v_d    = slot_v_q;
        slot_data_d = slot_data_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (slot_v_q[i] && resp_ready[i]) begin
                slot_v_d[i]                        = 1'b0;
                slot_data_d[i*DATA_W +: DATA_W] = '0;
            end
        end
        if (capture) begin
            slot_v_d[exit_idx]                        = 1'b1;
            slot_data_d[exit_idx*DATA_W +: DATA_W] = tanh_y_out;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q       <= '0;
            slot_v_q    <= '0;
            slot_data_q <= '0;
        end else begin
            ptr_q       <= ptr_d;
            slot_v_q    <= slot_v_d;
            slot_data_q <= slot_data_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < TANH_LAT; s++) begin
                tag_v_q[s]   <= 1'b0;
                tag_idx_q[s] <= '0;
            end
        end else begin
            tag_v_q[0]   <= gnt_any;
            tag_idx_q[0] <= gnt_idx;
            for (int s = 1; s < TANH_LAT; s++) begin
                tag_v_q[s]   <= tag_v_q[s-1];
                tag_idx_q[s] <= tag_idx_q[s-1];
            end
        end
    end

    assign resp_valid = slot_v_q;
    assign resp_data  = slot_data_q;

`ifdef PWL_TANH_ARB_STATS_EN
    logic [31:0] grants_q, grants_d;
    logic [31:0] stall_q, stall_d;

    always_comb begin
        grants_d = grants_q;
        stall_d  = stall_q;
        if (stat_clr) begin
            grants_d = '0;
            stall_d  = '0;
        end else begin
            if (gnt_any && (grants_q != '1)) begin
                grants_d = grants_q + 32'd1;
            end
            if ((|req_valid) && !gnt_any && (stall_q != '1)) begin
                stall_d = stall_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grants_q <= '0;
            stall_q  <= '0;
        end else begin
            grants_q <= grants_d;
            stall_q  <= stall_d;
        end
    end

    assign stat_grants = grants_q;
    assign stat_stall  = stall_q;
`endif

`ifndef SYNTHESIS
    // The tanh unit must return exactly one result per issued sample,
    // TANH_LAT cycles later.
    a_tag_align: assert property (@(posedge clk) disable iff (!rst_n)
        tanh_valid_out == exit_v);
`endif

endmodule

// File: tb/tb_pwl_tanh_arbiter.sv
module tb_pwl_tanh_arbiter;

    localparam int NUM_REQ  = 4;
    localparam int DATA_W   = 16;
    localparam int TANH_LAT = 1;

    logic                      clk = 1'b0;
    logic                      rst_n = 1'b0;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        resp_valid;
    logic [NUM_REQ-1:0]        resp_ready;
    logic [NUM_REQ*DATA_W-1:0] resp_data;
    logic                      tanh_valid_in;
    logic [DATA_W-1:0]         tanh_x_in;
    logic                      tanh_valid_out;
    logic [DATA_W-1:0]         tanh_y_out;
`ifdef PWL_TANH_ARB_STATS_EN
    logic                      stat_clr;
    logic [31:0]               stat_grants;
    logic [31:0]               stat_stall;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pwl_tanh_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .TANH_LAT(TANH_LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .tanh_valid_in(tanh_valid_in), .tanh_x_in(tanh_x_in),
        .tanh_valid_out(tanh_valid_out), .tanh_y_out(tanh_y_out)
`ifdef PWL_TANH_ARB_STATS_EN
        , .stat_clr(stat_clr), .stat_grants(stat_grants), .stat_stall(stat_stall)
`endif
    );

    // Stand-in tanh unit: known Q8.8 points from the tanh curve, an arbitrary
    // but deterministic mapping elsewhere so routing errors stay visible.
    function automatic logic [15:0] tanh_f(input logic [15:0] x);
        case (x)
            16'd0:    return 16'd0;
            16'd128:  return 16'd118;
            16'd256:  return 16'd195;
            16'd1024: return 16'd256;
            16'hFC00: return 16'hFF00;
            default:  return x ^ 16'h5A3C;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tanh_valid_out <= 1'b0;
            tanh_y_out     <= '0;
        end else begin
            tanh_valid_out <= tanh_valid_in;
            tanh_y_out     <= tanh_f(tanh_x_in);
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_x(input int i, input logic [15:0] x);
        req_data[i*DATA_W +: DATA_W] = x;
    endtask

    function automatic logic [15:0] rd(input int i);
        return resp_data[i*DATA_W +: DATA_W];
    endfunction

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            req_valid  = '0;
            resp_ready = '1;
        end
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        int          idx;
        logic [15:0] x;
        logic [15:0] y;
    } vec_t;

    vec_t tbl[6];

    // Reference model state: slot contents plus a list of outstanding samples
    // with the cycle their result becomes visible.
    typedef struct {
        int          idx;
        logic [15:0] y;
        int          due;
    } fl_t;

    bit          m_v [NUM_REQ];
    logic [15:0] m_d [NUM_REQ];
    fl_t         fl[$];
    int          m_ptr;
    int          cyc_n;

    function automatic bit m_inflight(input int i);
        foreach (fl[q]) if (fl[q].idx == i) return 1'b1;
        return 1'b0;
    endfunction

    logic [15:0] a4x [4];
    logic [15:0] a4y [4];
    logic [3:0]  mask;
    logic [3:0]  e_rdy;
    logic [3:0]  e_rv;
    logic [15:0] e_x;
    int          g, last_g, viol, gcnt0;
    int          prev_s [2];
    int          maxgap [2];
    int          nsel [2];

    initial begin
        req_valid  = '0;
        resp_ready = '1;
        req_data   = '0;
`ifdef PWL_TANH_ARB_STATS_EN
        stat_clr   = 1'b0;
`endif
        tbl[0] = '{0, 16'd256,  16'd195};
        tbl[1] = '{1, 16'd128,  16'd118};
        tbl[2] = '{2, 16'd1024, 16'd256};
        tbl[3] = '{3, 16'hFC00, 16'hFF00};
        tbl[4] = '{0, 16'd0,    16'd0};
        tbl[5] = '{3, 16'h1357, 16'h1357 ^ 16'h5A3C};
        a4x = '{16'd0, 16'd128, 16'd1024, 16'hFC00};
        a4y = '{16'd0, 16'd118, 16'd256,  16'hFF00};

        // Reset state, with every requester asking.
        #2;
        req_valid = '1;
        #1;
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_tvalid", 64'(tanh_valid_in), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_resp_data", 64'(resp_data), 64'd0);
        repeat (3) @(negedge clk);
        chk("rst_hold_resp_valid", 64'(resp_valid), 64'd0);
        req_valid = '0;
        rst_n = 1'b1;

        // All four at once: grants 0,1,2,3 on consecutive cycles.
        for (int i = 0; i < NUM_REQ; i++) set_x(i, a4x[i]);
        mask = 4'hF;
        for (int s = 0; s < 6; s++) begin
            @(negedge clk);
            req_valid = mask;
            #1;
            if (s < 4) begin
                e_rdy = '0;
                e_rdy[s] = 1'b1;
                chk("all4_grant", 64'(req_ready), 64'(e_rdy));
                chk("all4_x", 64'(tanh_x_in), 64'(a4x[s]));
            end
            if (s >= 2) begin
                e_rv = '0;
                e_rv[s-2] = 1'b1;
                chk("all4_resp_valid", 64'(resp_valid), 64'(e_rv));
                chk("all4_resp_data", 64'(rd(s-2)), 64'(a4y[s-2]));
            end
            if (s < 4) mask[s] = 1'b0;
        end
        idle(3);

        // Single requester vectors: accept, one cycle in flight, result.
        foreach (tbl[v]) begin
            @(negedge clk);
            resp_ready = '1;
            set_x(tbl[v].idx, tbl[v].x);
            req_valid = '0;
            req_valid[tbl[v].idx] = 1'b1;
            #1;
            e_rdy = '0;
            e_rdy[tbl[v].idx] = 1'b1;
            chk("vec_ready", 64'(req_ready), 64'(e_rdy));
            chk("vec_tvalid", 64'(tanh_valid_in), 64'd1);
            @(negedge clk);
            req_valid = '0;
            #1;
            chk("vec_resp_early", 64'(resp_valid), 64'd0);
            @(negedge clk);
            #1;
            chk("vec_resp_valid", 64'(resp_valid), 64'(e_rdy));
            chk("vec_resp_data", 64'(rd(tbl[v].idx)), 64'(tbl[v].y));
            @(negedge clk);
            #1;
            chk("vec_resp_clear", 64'(resp_valid), 64'd0);
        end

        // Fairness between two always-valid requesters.
        reset_dut();
        last_g = -1; viol = 0;
        prev_s = '{0, 0}; maxgap = '{0, 0}; nsel = '{0, 0};
        for (int s = 0; s < 24; s++) begin
            @(negedge clk);
            resp_ready = '1;
            req_valid = 4'b0011;
            set_x(0, 16'($urandom));
            set_x(1, 16'($urandom));
            #1;
            g = -1;
            if (req_ready == 4'b0001) g = 0;
            else if (req_ready == 4'b0010) g = 1;
            else if (req_ready != 4'b0000) viol++;
            if (g >= 0) begin
                if (g == last_g) viol++;
                if (s - prev_s[g] > maxgap[g]) maxgap[g] = s - prev_s[g];
                prev_s[g] = s;
                nsel[g]++;
                last_g = g;
            end
        end
        chk("fair_alternation_violations", 64'(viol), 64'd0);
        chk("fair_gap0_within_num_req", 64'(maxgap[0] <= NUM_REQ), 64'd1);
        chk("fair_gap1_within_num_req", 64'(maxgap[1] <= NUM_REQ), 64'd1);
        chk("fair_grant_count", 64'(nsel[0] >= 7 && nsel[1] >= 7), 64'd1);
        idle(3);

        // Backpressure on requester 2 while requester 0 keeps flowing.
        @(negedge clk);
        resp_ready = 4'b1011;
        set_x(2, 16'd256);
        req_valid = 4'b0100;
        #1;
        chk("bp_first_grant", 64'(req_ready), 64'b0100);
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        #1;
        chk("bp_slot_full", 64'(resp_valid[2]), 64'd1);
        chk("bp_slot_data", 64'(rd(2)), 64'd195);
        gcnt0 = 0;
        for (int s = 0; s < 10; s++) begin
            @(negedge clk);
            req_valid = 4'b0101;
            set_x(0, 16'($urandom));
            set_x(2, 16'($urandom));
            #1;
            chk("bp_hold_valid", 64'(resp_valid[2]), 64'd1);
            chk("bp_hold_data", 64'(rd(2)), 64'd195);
            chk("bp_no_ready2", 64'(req_ready[2]), 64'd0);
            if (req_ready[0]) gcnt0++;
        end
        chk("bp_others_served", 64'(gcnt0 >= 3), 64'd1);
        // Response handshake and new request in the same cycle.
        @(negedge clk);
        req_valid = 4'b0100;
        resp_ready = '1;
        #1;
        chk("same_cycle_not_granted", 64'(req_ready), 64'd0);
        chk("same_cycle_resp_valid", 64'(resp_valid[2]), 64'd1);
        @(negedge clk);
        #1;
        chk("next_cycle_granted", 64'(req_ready), 64'b0100);
        idle(4);

        // Reset one cycle after a grant.
        @(negedge clk);
        set_x(1, 16'd256);
        req_valid = 4'b0010;
        #1;
        chk("rmid_grant", 64'(req_ready), 64'b0010);
        @(negedge clk);
        rst_n = 1'b0;
        req_valid = '1;
        #1;
        chk("rmid_ready_low", 64'(req_ready), 64'd0);
        chk("rmid_tvalid_low", 64'(tanh_valid_in), 64'd0);
        chk("rmid_resp_valid", 64'(resp_valid), 64'd0);
        @(negedge clk);
        @(negedge clk);
        req_valid = '0;
        rst_n = 1'b1;
        #1;
        chk("rmid_rel_resp_valid", 64'(resp_valid), 64'd0);
        chk("rmid_rel_resp_data", 64'(resp_data), 64'd0);
        chk("rmid_rel_tvalid", 64'(tanh_valid_in), 64'd0);
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            #1;
            chk("rmid_no_spurious", 64'(resp_valid), 64'd0);
        end

`ifdef PWL_TANH_ARB_STATS_EN
        // 5 grants and 3 stalled cycles, then a clear racing an increment.
        reset_dut();
        for (int s = 0; s < 10; s++) begin
            @(negedge clk);
            req_valid  = (s < 7) ? 4'hF : ((s == 8) ? 4'h1 : 4'h0);
            resp_ready = (s == 7) ? 4'hF : 4'h0;
        end
        @(negedge clk);
        req_valid = 4'h1;
        stat_clr = 1'b1;
        #1;
        chk("stat_grants", 64'(stat_grants), 64'd5);
        chk("stat_stall", 64'(stat_stall), 64'd3);
        @(negedge clk);
        stat_clr = 1'b0;
        req_valid = '0;
        #1;
        chk("stat_clr_grants", 64'(stat_grants), 64'd0);
        chk("stat_clr_stall", 64'(stat_stall), 64'd0);
        idle(4);
`endif

        // Randomized traffic against the reference model.
        reset_dut();
        foreach (m_v[i]) begin m_v[i] = 1'b0; m_d[i] = '0; end
        fl.delete();
        m_ptr = 0;
        cyc_n = 0;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            req_valid = 4'($urandom);
            for (int i = 0; i < NUM_REQ; i++) begin
                resp_ready[i] = ($urandom_range(0, 3) != 0);
                set_x(i, 16'($urandom));
            end
            #1;
            g = -1;
            for (int k = 0; k < NUM_REQ; k++) begin
                int j;
                j = (m_ptr + k) % NUM_REQ;
                if (g < 0 && req_valid[j] && !m_v[j] && !m_inflight(j)) g = j;
            end
            e_rdy = '0;
            e_x = '0;
            if (g >= 0) begin
                e_rdy[g] = 1'b1;
                e_x = req_data[g*DATA_W +: DATA_W];
            end
            e_rv = '0;
            foreach (m_v[i]) e_rv[i] = m_v[i];
            chk("rnd_req_ready", 64'(req_ready), 64'(e_rdy));
            chk("rnd_tvalid", 64'(tanh_valid_in), 64'(g >= 0));
            chk("rnd_tx", 64'(tanh_x_in), 64'(e_x));
            chk("rnd_resp_valid", 64'(resp_valid), 64'(e_rv));
            foreach (m_v[i]) if (m_v[i]) chk("rnd_resp_data", 64'(rd(i)), 64'(m_d[i]));

            foreach (m_v[i]) if (m_v[i] && resp_ready[i]) m_v[i] = 1'b0;
            for (int q = fl.size() - 1; q >= 0; q--) begin
                if (fl[q].due == cyc_n + 1) begin
                    m_v[fl[q].idx] = 1'b1;
                    m_d[fl[q].idx] = fl[q].y;
                    fl.delete(q);
                end
            end
            if (g >= 0) begin
                fl.push_back('{g, tanh_f(e_x), cyc_n + TANH_LAT + 1});
                m_ptr = (g + 1) % NUM_REQ;
            end
            cyc_n++;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
